// File: rtl/alu_result_drain_if.sv
// rtl/alu_result_drain_if.sv - capture/stream/summary signal bundle for alu_result_drain
interface alu_result_drain_if #(
  parameter int LANES = 4,
  parameter int W     = 8
);
  localparam int LW = $clog2(LANES);
  localparam int MW = 2 * W + 1;
  localparam int SW = MW + LW;

  logic                      capture;
  logic [LANES-1:0][W-1:0]   in_r;
  logic [LANES-1:0][W-1:0]   in_i;
  logic                      busy;
  logic                      out_valid;
  logic                      out_ready;
  logic [LW-1:0]             out_lane;
  logic [W-1:0]              out_r;
  logic [W-1:0]              out_i;
  logic [MW-1:0]             out_mag;
  logic                      out_last;
  logic [SW-1:0]             sum_mag;
  logic                      sum_valid;
  logic                      overrun;

  // Producer/consumer side: drives lane results and accepts beats.
  modport master (
    output capture, in_r, in_i, out_ready,
    input  busy, out_valid, out_lane, out_r, out_i, out_mag, out_last,
           sum_mag, sum_valid, overrun
  );

  // Drain stage side.
  modport slave (
    input  capture, in_r, in_i, out_ready,
    output busy, out_valid, out_lane, out_r, out_i, out_mag, out_last,
           sum_mag, sum_valid, overrun
  );
endinterface

// File: rtl/alu_result_drain.sv
// rtl/alu_result_drain.sv - snapshot ALU lanes and stream per-lane |z|^2 with a frame total
module alu_result_drain #(
  parameter int LANES = 4,
  parameter int W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_drain_if.slave   bus
);
  localparam int LW = $clog2(LANES);
  localparam int MW = 2 * W + 1;
  localparam int SW = MW + LW;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic            overrun_q, overrun_d;
  logic            take_capture;

  logic [W-1:0]    buf_r_q [LANES];
  logic [W-1:0]    buf_i_q [LANES];
  logic [MW-1:0]   buf_m_q [LANES];

  logic signed [2*W-1:0] ext_r [LANES];
  logic signed [2*W-1:0] ext_i [LANES];
  logic signed [2*W-1:0] sq_r  [LANES];
  logic signed [2*W-1:0] sq_i  [LANES];
  logic [MW-1:0]         mag_in [LANES];

  // Square each incoming lane; squares are non-negative and fit 2W bits, so zero-extend before adding.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      ext_r[l]  = $signed({{W{bus.in_r[l][W-1]}}, bus.in_r[l]});
      ext_i[l]  = $signed({{W{bus.in_i[l][W-1]}}, bus.in_i[l]});
      sq_r[l]   = ext_r[l] * ext_r[l];
      sq_i[l]   = ext_i[l] * ext_i[l];
      mag_in[l] = {1'b0, sq_r[l]} + {1'b0, sq_i[l]};
    end
  end

  // Next-state, running sum and stream outputs; beat fields are zero whenever no beat is offered.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sum_d         = sum_q;
    overrun_d     = overrun_q;
    take_capture  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_lane  = '0;
    bus.out_r     = '0;
    bus.out_i     = '0;
    bus.out_mag   = '0;
    bus.out_last  = 1'b0;
    bus.sum_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.capture) begin
          take_capture = 1'b1;
          idx_d        = '0;
          sum_d        = '0;
          state_d      = SEND;
        end
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.out_lane  = idx_q;
        bus.out_r     = buf_r_q[idx_q];
        bus.out_i     = buf_i_q[idx_q];
        bus.out_mag   = buf_m_q[idx_q];
        bus.out_last  = (idx_q == LW'(LANES - 1));
        if (bus.capture) overrun_d = 1'b1;
        if (bus.out_ready) begin
          sum_d = sum_q + {{LW{1'b0}}, buf_m_q[idx_q]};
          if (idx_q == LW'(LANES - 1)) state_d = DONE;
          else                         idx_d   = idx_q + LW'(1);
        end
      end
      DONE: begin
        bus.sum_valid = 1'b1;
        if (bus.capture) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.sum_mag = sum_q;
  assign bus.overrun = overrun_q;

  // State, counters and lane buffers; buffers only load on a capture accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sum_q     <= '0;
      overrun_q <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        buf_r_q[l] <= '0;
        buf_i_q[l] <= '0;
        buf_m_q[l] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      overrun_q <= overrun_d;
      if (take_capture) begin
        for (int l = 0; l < LANES; l++) begin
          buf_r_q[l] <= bus.in_r[l];
          buf_i_q[l] <= bus.in_i[l];
          buf_m_q[l] <= mag_in[l];
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_result_drain.sv
// tb/tb_alu_result_drain.sv - scoreboard bench for alu_result_drain
module tb_alu_result_drain;
  localparam int LANES = 4;
  localparam int W     = 8;

  typedef struct {
    logic [1:0]  lane;
    logic [7:0]  r;
    logic [7:0]  i;
    logic [16:0] mag;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   tr[LANES];
  int   ti[LANES];
  int   tm[LANES];
  int   tsum;
  beat_t beat_q[$];
  int    sum_q[$];

  alu_result_drain_if #(.LANES(LANES), .W(W)) bus ();

  alu_result_drain #(.LANES(LANES), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Directed vectors with hand-computed magnitudes and totals.
  task automatic load(input int sel);
    case (sel)
      0: begin
        tr = '{3, -5, -128, 0};  ti = '{4, 12, -128, 0};
        tm = '{25, 169, 32768, 0}; tsum = 32962;
      end
      1: begin
        tr = '{1, 1, 1, 1};  ti = '{1, 1, 1, 1};
        tm = '{2, 2, 2, 2};  tsum = 8;
      end
      2: begin
        tr = '{-1, -1, -1, -1}; ti = '{0, 0, 0, 0};
        tm = '{1, 1, 1, 1};     tsum = 4;
      end
      default: begin
        tr = '{7, 9, 11, 13}; ti = '{-7, -9, -11, -13};
        tm = '{98, 162, 242, 338}; tsum = 840;
      end
    endcase
    for (int l = 0; l < LANES; l++) begin
      bus.in_r[l] = 8'(tr[l]);
      bus.in_i[l] = 8'(ti[l]);
    end
  endtask

  task automatic start_frame(input int sel, input bit expect_frame);
    beat_t b;
    load(sel);
    bus.capture = 1'b1;
    @(posedge clk);
    #1;
    bus.capture = 1'b0;
    if (expect_frame) begin
      for (int l = 0; l < LANES; l++) begin
        b.lane = 2'(l);
        b.r    = 8'(tr[l]);
        b.i    = 8'(ti[l]);
        b.mag  = 17'(tm[l]);
        b.last = (l == LANES - 1);
        beat_q.push_back(b);
      end
      sum_q.push_back(tsum);
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = bus.sum_valid;
    end
    chk("frame_done_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every offered beat with the queue head; pops only on transfer.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (beat_q.size() == 0) begin
        chk("beat_unexpected", 32'd1, 32'd0);
      end else begin
        chk("beat_lane", 32'(bus.out_lane), 32'(beat_q[0].lane));
        chk("beat_r",    32'(bus.out_r),    32'(beat_q[0].r));
        chk("beat_i",    32'(bus.out_i),    32'(beat_q[0].i));
        chk("beat_mag",  32'(bus.out_mag),  32'(beat_q[0].mag));
        chk("beat_last", 32'(bus.out_last), 32'(beat_q[0].last));
        if (bus.out_ready === 1'b1) void'(beat_q.pop_front());
      end
    end
    if (bus.sum_valid === 1'b1) begin
      if (sum_q.size() == 0) chk("sum_unexpected", 32'd1, 32'd0);
      else chk("sum_mag", 32'(bus.sum_mag), 32'(sum_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.capture   = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_r      = '0;
    bus.in_i      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy",      32'(bus.busy), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_lane",  32'(bus.out_lane), 0);
    chk("rst_out_mag",   32'(bus.out_mag), 0);
    chk("rst_out_last",  32'(bus.out_last), 0);
    chk("rst_sum_mag",   32'(bus.sum_mag), 0);
    chk("rst_sum_valid", 32'(bus.sum_valid), 0);
    chk("rst_overrun",   32'(bus.overrun), 0);

    // Frame 1: ready high, exact latency
    start_frame(0, 1'b1);
    for (int c = 0; c < LANES; c++) begin
      @(negedge clk);
      chk("f1_busy", 32'(bus.busy), 1);
      chk("f1_sum_valid_early", 32'(bus.sum_valid), 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("f1_sum_valid_k5", 32'(bus.sum_valid), 1);
    chk("f1_sum_mag", 32'(bus.sum_mag), 32962);
    @(posedge clk);
    @(negedge clk);
    chk("f1_idle_busy", 32'(bus.busy), 0);
    chk("f1_sum_hold", 32'(bus.sum_mag), 32962);
    chk("f1_sum_valid_once", 32'(bus.sum_valid), 0);

    // Backpressure on lane 1 for 3 cycles
    start_frame(0, 1'b1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_lane_held", 32'(bus.out_lane), 1);
    bus.out_ready = 1'b1;
    wait_done();
    chk("bp_sum", 32'(bus.sum_mag), 32962);

    // Capture during SEND: ignored, overrun sticky
    start_frame(0, 1'b1);
    @(posedge clk);
    #1;
    start_frame(3, 1'b0);
    @(negedge clk);
    chk("ovr_set", 32'(bus.overrun), 1);
    wait_done();
    chk("ovr_sum_orig", 32'(bus.sum_mag), 32962);
    chk("ovr_sticky", 32'(bus.overrun), 1);
    start_frame(1, 1'b1);
    wait_done();
    chk("ovr_next_sum", 32'(bus.sum_mag), 8);
    chk("ovr_sticky2", 32'(bus.overrun), 1);

    // Reset during lane 2
    start_frame(0, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rmid_lane2", 32'(bus.out_lane), 2);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    beat_q.delete();
    sum_q.delete();
    @(negedge clk);
    chk("rmid_busy",      32'(bus.busy), 0);
    chk("rmid_out_valid", 32'(bus.out_valid), 0);
    chk("rmid_out_lane",  32'(bus.out_lane), 0);
    chk("rmid_out_r",     32'(bus.out_r), 0);
    chk("rmid_out_i",     32'(bus.out_i), 0);
    chk("rmid_out_mag",   32'(bus.out_mag), 0);
    chk("rmid_out_last",  32'(bus.out_last), 0);
    chk("rmid_sum_mag",   32'(bus.sum_mag), 0);
    chk("rmid_sum_valid", 32'(bus.sum_valid), 0);
    chk("rmid_overrun",   32'(bus.overrun), 0);
    repeat (3) @(negedge clk);
    chk("rmid_no_sum_valid", 32'(bus.sum_valid), 0);
    #1;
    start_frame(1, 1'b1);
    wait_done();
    chk("rmid_next_sum", 32'(bus.sum_mag), 8);

    // Capture and reset together: reset wins
    load(0);
    bus.capture = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.capture = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("cr_out_valid", 32'(bus.out_valid), 0);
    chk("cr_busy",      32'(bus.busy), 0);
    chk("cr_overrun",   32'(bus.overrun), 0);
    @(negedge clk);
    chk("cr_out_valid2", 32'(bus.out_valid), 0);
    #1;

    // Back-to-back frames, capture on first IDLE cycle after DONE
    start_frame(0, 1'b1);
    wait_done();
    start_frame(2, 1'b1);
    @(negedge clk);
    chk("b2b_busy", 32'(bus.busy), 1);
    chk("b2b_sum_cleared", 32'(bus.sum_mag), 0);
    wait_done();
    chk("b2b_sum", 32'(bus.sum_mag), 4);
    chk("b2b_overrun", 32'(bus.overrun), 0);

    repeat (2) @(negedge clk);
    chk("sb_beats_empty", 32'(beat_q.size()), 0);
    chk("sb_sums_empty",  32'(sum_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
